// File: rtl/beat_pack.sv
// Packs BEATS narrow beats into one wide word on a registered valid/ready output.
// A beat flagged last_up closes the word early; keep_down marks the filled lanes.
module beat_pack #(
  parameter int DATA_W = 3,
  parameter int BEATS  = 4,
  localparam int OUT_W = DATA_W * BEATS,
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              valid_up,
  input  logic [DATA_W-1:0] data_up,
  input  logic              last_up,
  output logic              ready_up,
  output logic              valid_down,
  output logic [OUT_W-1:0]  data_down,
  output logic [BEATS-1:0]  keep_down,
  input  logic              ready_down
);

  // Handshake: a transfer happens on any rising edge where valid && ready are both 1.
  // The output word is held stable while valid_down=1 and ready_down=0; ready_up is
  // driven only from the output-register state and ready_down, never from valid_up.

  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] acc;
  logic [BEATS-1:0] acc_keep;

  logic [OUT_W-1:0] acc_next;
  logic [BEATS-1:0] keep_next;
  logic             accept;
  logic             close;
  logic             drain;

  assign ready_up = ~valid_down | ready_down;
  assign accept   = valid_up & ready_up;
  assign close    = accept & ((idx == IDX_W'(BEATS - 1)) | last_up);
  assign drain    = valid_down & ready_down;

  always_comb begin
    acc_next  = acc;
    keep_next = acc_keep;
    for (int i = 0; i < BEATS; i++) begin
      if (idx == IDX_W'(i)) begin
        acc_next[i*DATA_W +: DATA_W] = data_up;
        keep_next[i]                 = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx        <= '0;
      acc        <= '0;
      acc_keep   <= '0;
      valid_down <= 1'b0;
      data_down  <= '0;
      keep_down  <= '0;
    end else if (close) begin
      // A close on the drain cycle simply overwrites the outgoing word: no bubble.
      data_down  <= acc_next;
      keep_down  <= keep_next;
      valid_down <= 1'b1;
      idx        <= '0;
      acc        <= '0;
      acc_keep   <= '0;
    end else begin
      if (accept) begin
        acc      <= acc_next;
        acc_keep <= keep_next;
        idx      <= idx + IDX_W'(1);
      end
      if (drain) begin
        valid_down <= 1'b0;
      end
    end
  end

  a_hold_stable: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (valid_down && !ready_down) |=> (valid_down && $stable(data_down) && $stable(keep_down)));

  a_idx_range: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    idx <= IDX_W'(BEATS - 1));

endmodule

// File: tb/tb_beat_pack.sv
// Directed bench for beat_pack: a vector table for the steady-state cases plus
// hand-written sequences for back-pressure and mid-word reset.
module tb_beat_pack;
  localparam int DATA_W = 3;
  localparam int BEATS  = 4;
  localparam int OUT_W  = DATA_W * BEATS;

  logic              sys_clk    = 1'b0;
  logic              sys_rst_n  = 1'b0;
  logic              valid_up   = 1'b0;
  logic [DATA_W-1:0] data_up    = '0;
  logic              last_up    = 1'b0;
  logic              ready_down = 1'b0;
  logic              ready_up;
  logic              valid_down;
  logic [OUT_W-1:0]  data_down;
  logic [BEATS-1:0]  keep_down;

  int n_pass  = 0;
  int n_total = 0;
  logic [OUT_W-1:0] exp_q[$];

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              l;
    logic              r;
    logic              e_rdy;
    logic              e_v;
    logic [OUT_W-1:0]  e_d;
    logic [BEATS-1:0]  e_k;
  } vec_t;

  vec_t tbl[$];

  beat_pack #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .valid_up  (valid_up),
    .data_up   (data_up),
    .last_up   (last_up),
    .ready_up  (ready_up),
    .valid_down(valid_down),
    .data_down (data_down),
    .keep_down (keep_down),
    .ready_down(ready_down)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic r);
    valid_up   = v;
    data_up    = d;
    last_up    = l;
    ready_down = r;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply(input vec_t t, input int i);
    drive(t.v, t.d, t.l, t.r);
    #1;
    check($sformatf("vec%0d ready_up", i), 32'(ready_up), 32'(t.e_rdy));
    @(posedge sys_clk);
    #1;
    check($sformatf("vec%0d valid_down", i), 32'(valid_down), 32'(t.e_v));
    check($sformatf("vec%0d data_down", i), 32'(data_down), 32'(t.e_d));
    check($sformatf("vec%0d keep_down", i), 32'(keep_down), 32'(t.e_k));
  endtask

  // scoreboard: wait (bounded) for a valid word and compare against the queue head
  task automatic wait_word(input string name, input logic [BEATS-1:0] exp_keep);
    logic [OUT_W-1:0] exp_d;
    int n = 0;
    while (!valid_down && n < 8) begin
      step();
      n++;
    end
    check({name, " valid_down"}, 32'(valid_down), 32'd1);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({name, " data_down"}, 32'(data_down), 32'(exp_d));
    check({name, " keep_down"}, 32'(keep_down), 32'(exp_keep));
  endtask

  initial begin
    // vector table: inputs for one cycle, ready_up before the edge, outputs after it
    tbl.push_back('{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0000, 4'b0000});
    tbl.push_back('{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0000, 4'b0000});
    tbl.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0000, 4'b0000});
    tbl.push_back('{1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 12'o4321, 4'b1111});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 12'o4321, 4'b1111});
    tbl.push_back('{1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 12'o4321, 4'b1111});
    tbl.push_back('{1'b1, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 12'o4321, 4'b1111});
    tbl.push_back('{1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12'o0765, 4'b1111});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0765, 4'b1111});
    tbl.push_back('{1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0765, 4'b1111});
    tbl.push_back('{1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 12'o0065, 4'b0011});
    tbl.push_back('{1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 12'o0007, 4'b0001});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0007, 4'b0001});
    tbl.push_back('{1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 12'o0007, 4'b0001});
    tbl.push_back('{1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0007, 4'b0001});
    tbl.push_back('{1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0007, 4'b0001});
    tbl.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0007, 4'b0001});
    tbl.push_back('{1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 12'o4312, 4'b1111});
    tbl.push_back('{1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 12'o0005, 4'b0001});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o0005, 4'b0001});
    tbl.push_back('{1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 12'o0005, 4'b0001});
    tbl.push_back('{1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 12'o0006, 4'b0001});
    tbl.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'o0006, 4'b0001});

    // reset state
    @(posedge sys_clk);
    #1;
    check("reset valid_down", 32'(valid_down), 32'd0);
    check("reset data_down", 32'(data_down), 32'd0);
    check("reset keep_down", 32'(keep_down), 32'd0);
    check("reset ready_up", 32'(ready_up), 32'd1);
    sys_rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // back-pressure: word completes with ready_down=0 and is held for 5 cycles
    exp_q.push_back(12'o4321);
    exp_q.push_back(12'o0765);
    for (int b = 1; b <= 4; b++) begin
      drive(1'b1, 3'(b), 1'b0, 1'b0);
      #1;
      check($sformatf("bp fill%0d ready_up", b), 32'(ready_up), 32'd1);
      step();
    end
    wait_word("bp word0", 4'b1111);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 3'd5, 1'b0, 1'b0);
      #1;
      check($sformatf("bp hold%0d ready_up", c), 32'(ready_up), 32'd0);
      check($sformatf("bp hold%0d data_down", c), 32'(data_down), 32'(12'o4321));
      check($sformatf("bp hold%0d keep_down", c), 32'(keep_down), 32'(4'b1111));
      step();
      check($sformatf("bp hold%0d valid_down", c), 32'(valid_down), 32'd1);
    end
    drive(1'b1, 3'd5, 1'b0, 1'b1);
    #1;
    check("bp release ready_up", 32'(ready_up), 32'd1);
    step();
    check("bp release valid_down", 32'(valid_down), 32'd0);
    for (int b = 6; b <= 8; b++) begin
      drive(1'b1, 3'(b % 8), 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    wait_word("bp word1", 4'b1111);
    step();

    // reset drops a pending word at once
    drive(1'b1, 3'd3, 1'b1, 1'b0);
    step();
    check("pend valid_down", 32'(valid_down), 32'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst pend valid_down", 32'(valid_down), 32'd0);
    check("rst pend data_down", 32'(data_down), 32'd0);
    check("rst pend keep_down", 32'(keep_down), 32'd0);
    check("rst pend ready_up", 32'(ready_up), 32'd1);
    step();
    sys_rst_n = 1'b1;

    // reset mid-word discards the two accepted beats
    drive(1'b1, 3'd1, 1'b0, 1'b1);
    step();
    drive(1'b1, 3'd2, 1'b0, 1'b1);
    step();
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst mid valid_down", 32'(valid_down), 32'd0);
    check("rst mid keep_down", 32'(keep_down), 32'd0);
    step();
    sys_rst_n = 1'b1;
    exp_q.push_back(12'o7654);
    for (int b = 4; b <= 7; b++) begin
      drive(1'b1, 3'(b), 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    wait_word("post rst word", 4'b1111);
    step();
    check("post rst drain valid_down", 32'(valid_down), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
